// File: rtl/ahb_bus_master_pkg.sv
// ahb_bus_master shared constants: AHB encodings, FSM states, helpers.
// Provides the default `WORD_WIDTH when the codebase has not set it.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package ahb_bus_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR2 = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b1;
        unique case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = lo[0];
            HSIZE_WORD: bad = |lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_bus_master_if.sv
// LSU request/response handshake plus the CPU-side AHB-Lite signals.
// master = the bus master's view, slave = the environment's view.
interface ahb_bus_master_if;

    logic                   lsu_req_valid;
    logic                   lsu_req_ready;
    logic [`WORD_WIDTH-1:0] lsu_req_addr;
    logic                   lsu_req_we;
    logic [1:0]             lsu_req_size;
    logic [`WORD_WIDTH-1:0] lsu_req_wdata;
    logic                   lsu_resp_valid;
    logic [`WORD_WIDTH-1:0] lsu_resp_rdata;
    logic                   lsu_resp_err;

    logic [`WORD_WIDTH-1:0] CPU_HADDR;
    logic [1:0]             CPU_HTRANS;
    logic                   CPU_HWRITE;
    logic [2:0]             CPU_HSIZE;
    logic [`WORD_WIDTH-1:0] CPU_HWDATA;
    logic [`WORD_WIDTH-1:0] CPU_HRDATA;
    logic                   CPU_HREADY;
    logic [1:0]             CPU_HRESP;

    modport master (
        input  lsu_req_valid, lsu_req_addr, lsu_req_we,
        input  lsu_req_size, lsu_req_wdata,
        output lsu_req_ready,
        output lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        output CPU_HADDR, CPU_HTRANS, CPU_HWRITE, CPU_HSIZE,
        output CPU_HWDATA,
        input  CPU_HRDATA, CPU_HREADY, CPU_HRESP
    );

    modport slave (
        output lsu_req_valid, lsu_req_addr, lsu_req_we,
        output lsu_req_size, lsu_req_wdata,
        input  lsu_req_ready,
        input  lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        input  CPU_HADDR, CPU_HTRANS, CPU_HWRITE, CPU_HSIZE,
        input  CPU_HWDATA,
        output CPU_HRDATA, CPU_HREADY, CPU_HRESP
    );

endinterface

// File: rtl/ahb_bus_master.sv
// Single-outstanding AHB-Lite master for the LSU, with alignment
// checking and a data-phase timeout for unmapped addresses.
module ahb_bus_master
    import ahb_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ahb_bus_master_if.master bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state_q;
    logic [`WORD_WIDTH-1:0] addr_q;
    logic                   we_q;
    logic [1:0]             size_q;
    logic [`WORD_WIDTH-1:0] wdata_q;
    logic [`WORD_WIDTH-1:0] rdata_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;

    logic bus_err;
    logic timed_out;

    assign bus_err   = (bus.CPU_HRESP == HRESP_ERROR);
    assign timed_out = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.lsu_req_valid) begin
                        addr_q  <= bus.lsu_req_addr;
                        we_q    <= bus.lsu_req_we;
                        size_q  <= bus.lsu_req_size;
                        wdata_q <= bus.lsu_req_wdata;
                        rdata_q <= '0;
                        err_q   <= misaligned(bus.lsu_req_size,
                                              bus.lsu_req_addr[1:0]);
                        state_q <= misaligned(bus.lsu_req_size,
                                              bus.lsu_req_addr[1:0])
                                   ? S_RESP : S_ADDR;
                    end
                end
                S_ADDR: begin
                    cnt_q   <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    // HREADY takes priority over a coincident timeout
                    if (bus.CPU_HREADY) begin
                        state_q <= S_RESP;
                        err_q   <= bus_err;
                        rdata_q <= (!we_q && !bus_err) ? bus.CPU_HRDATA : '0;
                    end else if (bus_err) begin
                        state_q <= S_ERR2;
                    end else if (timed_out) begin
                        state_q <= S_RESP;
                        err_q   <= 1'b1;
                    end
                end
                S_ERR2: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.CPU_HREADY || timed_out) begin
                        state_q <= S_RESP;
                        err_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lsu_req_ready  = (state_q == S_IDLE);
    assign bus.lsu_resp_valid = (state_q == S_RESP);
    assign bus.lsu_resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    assign bus.lsu_resp_err   = (state_q == S_RESP) && err_q;

    assign bus.CPU_HTRANS = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.CPU_HADDR  = addr_q;
    assign bus.CPU_HWRITE = we_q;
    assign bus.CPU_HSIZE  = {1'b0, size_q};
    assign bus.CPU_HWDATA = wdata_q;

endmodule

// File: doc/ahb_bus_master.md
Name: ahb_bus_master

Overview:
- Single-outstanding AHB-Lite master between the CPU load/store unit and the bus decoder/slave fabric.
- Converts LSU valid/ready requests into AHB address and data phases, and drives CPU_HADDR/HTRANS/HWRITE/HSIZE/HWDATA.
- Consumes the muxed CPU_HRDATA/HREADY/HRESP and returns one response per request.
- Adds alignment checking and a no-response timeout, because unmapped addresses never assert HREADY.

Parameters:
- TIMEOUT_CYCLES, 255: max data-phase cycles waiting for HREADY before an error completion. Legal range 1..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- lsu_req_valid  input  1  request present
- lsu_req_ready  output  1  request accepted when valid&ready
- lsu_req_addr  input  `WORD_WIDTH  byte address
- lsu_req_we  input  1  1=store, 0=load
- lsu_req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
- lsu_req_wdata  input  `WORD_WIDTH  lane-aligned store data
- lsu_resp_valid  output  1  one-cycle response pulse
- lsu_resp_rdata  output  `WORD_WIDTH  raw HRDATA word; 0 on error or store
- lsu_resp_err  output  1  bus error, timeout or misalignment
- CPU_HADDR  output  `WORD_WIDTH  AHB address
- CPU_HTRANS  output  2  IDLE=2'b00, NONSEQ=2'b10
- CPU_HWRITE  output  1  write strobe
- CPU_HSIZE  output  3  {1'b0, size}
- CPU_HWDATA  output  `WORD_WIDTH  write data
- CPU_HRDATA  input  `WORD_WIDTH  muxed read data
- CPU_HREADY  input  1  muxed ready
- CPU_HRESP  input  2  OKAY=2'b00, ERROR=2'b01

Behaviour:
- Interface timing is fixed: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - outputs: lsu_req_ready=1, lsu_resp_valid=0, lsu_resp_rdata=0, lsu_resp_err=0, CPU_HTRANS=IDLE, CPU_HADDR=0, CPU_HWRITE=0, CPU_HSIZE=0, CPU_HWDATA=0.
  - internal: state=IDLE, counter=0.
- FSM states: IDLE, ADDR, DATA, ERR2, RESP.
- IDLE
  - lsu_req_ready=1; on valid, register addr/we/size/wdata.
  - Misaligned request (size=3; size=1 with addr[0]=1; size=2 with addr[1:0]!=0) -> RESP with err=1. No bus transfer: HTRANS stays IDLE.
  - Aligned request -> ADDR.
- ADDR (exactly 1 cycle)
  - HTRANS=NONSEQ; HADDR/HWRITE/HSIZE from the registers.
  - Always -> DATA; counter cleared.
- DATA
  - HTRANS=IDLE; HADDR/HWRITE/HSIZE held so the decoder's select stays stable.
  - HWDATA = registered wdata (stores); counter increments each cycle.
  - HREADY=1 with HRESP=OKAY -> RESP, err=0; rdata captured from CPU_HRDATA (loads) or 0 (stores).
  - HREADY=0 with HRESP=ERROR -> ERR2.
  - HREADY=1 with HRESP=ERROR (single-cycle error) -> RESP, err=1.
  - counter == TIMEOUT_CYCLES-1 with no HREADY -> RESP, err=1, rdata=0.
  - If HREADY and timeout coincide, HREADY wins.
- ERR2: wait for HREADY=1 (timeout still counting) -> RESP, err=1, rdata=0.
- RESP
  - lsu_resp_valid=1 for exactly 1 cycle with rdata/err; lsu_req_ready=0.
  - -> IDLE. No response backpressure.
- lsu_req_ready=1 only in IDLE, so at most one request is in flight.
- Minimum latency for an aligned access with zero wait states:
  - accept at cycle N, ADDR at N+1, DATA samples HREADY at N+2, resp_valid at N+3.
  - Next request accepted at N+4.
- Misaligned latency: accept at N, resp_valid at N+1.
- Reset mid-transfer: immediate return to reset values; the pending transfer is dropped and produces no response.
- HWDATA is held from ADDR through DATA and ERR2, and is a don't-care otherwise.
- Byte-lane placement is the LSU's responsibility; this block does not shift data.

Decomposition:
- Shared defines header holds HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR, HSIZE_BYTE/HALF/WORD and the FSM state encodings.
- It reuses the existing `WORD_WIDTH.
- No sub-module; the timeout counter is inline.

Test Plan:
- Word load from a UART-model address, slave returns HRDATA=32'hA5A5_0001 with 0 wait states -> HTRANS=NONSEQ for 1 cycle; resp_valid at N+3, rdata=32'hA5A5_0001, err=0.
- Half store of 32'h0000_BEEF at an address ending in 2, slave inserts 3 wait states -> HADDR/HWRITE=1/HSIZE=3'b001 held for 4 DATA cycles; HWDATA=32'h0000_BEEF; resp_valid at N+6, err=0.
- Two-cycle ERROR response (HREADY=0/HRESP=01, then HREADY=1/HRESP=01) -> ERR2 entered; resp_err=1, rdata=0.
- Load to an unmapped address (HREADY stuck 0), TIMEOUT_CYCLES=8 -> resp_valid with err=1 exactly 8 DATA cycles after ADDR; returns to IDLE.
- Word access at address ending in 1, plus size=3 -> no NONSEQ issued; resp at N+1 with err=1.
- rst_n pulled low during DATA -> all outputs at reset values asynchronously; no resp_valid; next request after release completes normally.
